fetch_sequencer: RTL and testbench

- Multicycle instruction sequencer for the first core.
- Owns the PC, drives the instruction-memory read, and captures the returned word into `op` with a one-cycle `op_valid` pulse.
- Waits for the execute side to report completion (`write_finish` / `store_finish` / `jump_finish`), updates the PC, then starts the next fetch.
- Also provides halt control, a retired-instruction counter and a completion-timeout watchdog.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/wait_counter.sv | 34 +++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// +--------------------------------------------------------------------+
// | core_pkg : shared types and widths for the first-core sequencer     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package core_pkg;

  localparam int INSTR_W  = 32;
  localparam int RETIRE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer_if : instruction-memory and execute-side bus        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_sequencer_if
  import core_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] op;
  logic               op_valid;
  logic               write_finish;
  logic               store_finish;
  logic               jump_finish;
  logic [ADDR_W-1:0]  jump_target;

  modport master (
    output imem_en, imem_addr, op, op_valid,
    input  imem_rdata, write_finish, store_finish, jump_finish, jump_target
  );

  modport slave (
    input  imem_en, imem_addr, op, op_valid,
    output imem_rdata, write_finish, store_finish, jump_finish, jump_target
  );

endinterface

`default_nettype wire

// File: rtl/wait_counter.sv
// +--------------------------------------------------------------------+
// | wait_counter : loadable saturating down-counter with zero flag      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module wait_counter #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  input  wire logic         dec,
  output logic              zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer : multicycle fetch / wait-for-completion sequencer  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 2,
  parameter int                TIMEOUT  = 1024
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start,
  input  wire logic                halt_req,
  fetch_sequencer_if.master        bus,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy,
  output logic                     halted,
  output logic [RETIRE_W-1:0]      retired,
  output logic                     protocol_err
);

  localparam int LAT_W = 4;
  localparam int WD_W  = $clog2(TIMEOUT);

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic               w_finish;
  logic               w_complete;
  logic               w_timeout;
  logic               w_capture;
  logic               w_lat_zero;
  logic               w_wd_zero;
  logic               r_halt_pend;
  logic               r_imem_en;
  logic               r_op_valid;
  logic [INSTR_W-1:0] r_op;

  assign w_finish  = bus.write_finish | bus.store_finish | bus.jump_finish;
  assign w_capture = (r_state == S_WAIT) && w_lat_zero;

  // Counters are preloaded with N-1 so that zero marks the last cycle.
  wait_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (r_state == S_FETCH),
    .load_val (LAT_W'(MEM_LAT - 1)),
    .dec      (r_state == S_WAIT),
    .zero     (w_lat_zero)
  );

  wait_counter #(.W(WD_W)) u_wd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_capture),
    .load_val (WD_W'(TIMEOUT - 1)),
    .dec      (r_state == S_EXEC),
    .zero     (w_wd_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  if (w_lat_zero) w_next = S_EXEC;
      S_EXEC: begin
        // A completion on the final watchdog cycle still wins.
        if (w_finish) begin
          w_complete = 1'b1;
          w_next     = (r_halt_pend || halt_req) ? S_HALT : S_FETCH;
        end else if (w_wd_zero) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_HALT:  if (start) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      pc           <= RESET_PC;
      r_op         <= '0;
      r_imem_en    <= 1'b0;
      r_op_valid   <= 1'b0;
      retired      <= '0;
      protocol_err <= 1'b0;
      r_halt_pend  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_en  <= (w_next == S_FETCH);
      r_op_valid <= w_capture;
      if (w_capture) begin
        r_op <= bus.imem_rdata;
      end
      if (w_complete) begin
        pc      <= bus.jump_finish ? bus.jump_target : pc + ADDR_W'(1);
        retired <= retired + RETIRE_W'(1);
      end
      if (w_timeout || (w_finish && (r_state != S_EXEC))) begin
        protocol_err <= 1'b1;
      end
      if (w_next == S_HALT) begin
        r_halt_pend <= 1'b0;
      end else if (halt_req && busy) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

  assign busy          = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EXEC);
  assign halted        = (r_state == S_HALT);
  assign bus.imem_en   = r_imem_en;
  assign bus.imem_addr = pc;
  assign bus.op        = r_op;
  assign bus.op_valid  = r_op_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_fetch_sequencer : directed stimulus with queue-based scoreboard  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_sequencer;

  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              halt_req = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic [31:0]       retired;
  logic              protocol_err;

  int unsigned       cyc = 0;
  int unsigned       en_cyc = 0;
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       mem_p1 = '0;
  logic [31:0]       mem_p2 = '0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_op_q[$];

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (16'h0000),
    .MEM_LAT  (MEM_LAT),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .halt_req     (halt_req),
    .bus          (bus.master),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .retired      (retired),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a == '0) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  // Two-stage pipe gives data MEM_LAT=2 cycles after the imem_en cycle.
  always @(posedge clk) begin
    mem_p1 <= bus.imem_en ? mem_word(bus.imem_addr) : 32'h0;
    mem_p2 <= mem_p1;
  end
  assign bus.imem_rdata = mem_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.imem_en) begin
          en_cyc = cyc;
          if (exp_addr_q.size() == 0) begin
            check("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFFFFFF);
          end else begin
            check("fetch_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
          end
        end
        if (bus.op_valid) begin
          if (exp_op_q.size() == 0) begin
            check("unexpected_op_valid", bus.op, 32'hFFFFFFFF);
          end else begin
            check("op_word", bus.op, exp_op_q.pop_front());
          end
          check("fetch_latency", 32'(cyc - en_cyc), 32'(MEM_LAT + 1));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op_valid();
    for (int i = 0; i < 20; i++) begin
      if (bus.op_valid) break;
      tick();
    end
    check("op_valid_seen", 32'(bus.op_valid), 32'd1);
  endtask

  task automatic expect_fetch(input logic [ADDR_W-1:0] a, input logic with_op);
    exp_addr_q.push_back(a);
    if (with_op) exp_op_q.push_back(mem_word(a));
  endtask

  initial begin
    bus.write_finish = 1'b0;
    bus.store_finish = 1'b0;
    bus.jump_finish  = 1'b0;
    bus.jump_target  = '0;
    fork
      monitor_loop();
    join_none

    repeat (2) tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_flags", {26'd0, bus.imem_en, bus.op_valid, busy, halted, protocol_err, 1'b0}, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_op", bus.op, 32'h0);
    rst = 1'b0;

    // Basic fetch: start in cycle 0 -> imem_en cycle 1 -> op_valid cycle 4.
    tick();
    expect_fetch(16'h0000, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c1_imem_en", 32'(bus.imem_en), 32'd1);
    repeat (2) tick();
    check("c3_no_op_valid", 32'(bus.op_valid), 32'd0);
    tick();
    check("c4_op_valid", 32'(bus.op_valid), 32'd1);
    check("c4_op", bus.op, 32'hDEADBEEF);
    tick();
    check("c5_op_valid_pulse", 32'(bus.op_valid), 32'd0);
    bus.write_finish = 1'b1;
    expect_fetch(16'h0001, 1'b1);
    tick();
    bus.write_finish = 1'b0;
    check("c6_pc", 32'(pc), 32'h1);
    check("c6_imem_en", 32'(bus.imem_en), 32'd1);
    check("c6_retired", retired, 32'd1);

    // Jump plus store together, accepted in the op_valid cycle.
    wait_op_valid();
    bus.jump_finish  = 1'b1;
    bus.store_finish = 1'b1;
    bus.jump_target  = 16'h0040;
    expect_fetch(16'h0040, 1'b1);
    tick();
    bus.jump_finish  = 1'b0;
    bus.store_finish = 1'b0;
    check("jump_pc", 32'(pc), 32'h40);
    check("jump_retired", retired, 32'd2);

    // Halt request during WAIT takes effect after completion.
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_op_valid();
    bus.write_finish = 1'b1;
    tick();
    bus.write_finish = 1'b0;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'h41);
    check("halt_retired", retired, 32'd3);
    repeat (4) tick();
    check("halt_idle_bus", {30'd0, bus.imem_en, busy}, 32'h0);
    expect_fetch(16'h0041, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_op_valid();

    // Watchdog: TIMEOUT=8 EXEC cycles without completion.
    repeat (7) tick();
    check("wd_cycle8_not_halted", {30'd0, halted, protocol_err}, 32'h0);
    tick();
    check("wd_protocol_err", 32'(protocol_err), 32'd1);
    check("wd_halted", 32'(halted), 32'd1);
    check("wd_pc", 32'(pc), 32'h41);
    check("wd_retired", retired, 32'd3);

    // Asynchronous reset in the middle of WAIT.
    expect_fetch(16'h0041, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc", 32'(pc), 32'h0);
    check("mid_rst_flags", {26'd0, bus.imem_en, bus.op_valid, busy, halted, protocol_err, 1'b0}, 32'h0);
    check("mid_rst_retired", retired, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Finish pulse while IDLE is a protocol error only.
    bus.write_finish = 1'b1;
    tick();
    bus.write_finish = 1'b0;
    check("idle_fin_err", 32'(protocol_err), 32'd1);
    check("idle_fin_pc", 32'(pc), 32'h0);
    check("idle_fin_retired", retired, 32'h0);
    check("idle_fin_busy", 32'(busy), 32'd0);

    // Restart from RESET_PC; halt_req coincident with completion halts.
    expect_fetch(16'h0000, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_op_valid();
    bus.write_finish = 1'b1;
    halt_req = 1'b1;
    tick();
    bus.write_finish = 1'b0;
    halt_req = 1'b0;
    check("same_cycle_halt", 32'(halted), 32'd1);
    check("same_cycle_pc", 32'(pc), 32'h1);
    check("same_cycle_retired", retired, 32'd1);
    repeat (3) tick();

    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("op_queue_drained", 32'(exp_op_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
